// File: rtl/duft_ap_ctrl_hs_mc_if.sv
// duft_ap_ctrl_hs_mc_if: ap_ctrl_hs register-access bundle.
// addr/wr_data/rd_wr/ap_start in; ap_idle/ap_ready/ap_done/ap_return out.
interface duft_ap_ctrl_hs_mc_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        rd_wr;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [31:0] ap_return;

  modport master (
    output addr, wr_data, rd_wr, ap_start,
    input  ap_idle, ap_ready, ap_done, ap_return
  );

  modport slave (
    input  addr, wr_data, rd_wr, ap_start,
    output ap_idle, ap_ready, ap_done, ap_return
  );
endinterface

// File: rtl/duft_ap_ctrl_hs_mc.sv
// duft_ap_ctrl_hs_mc: multi-lane accumulator DUFT behind an ap_ctrl_hs regfile.
// Ports: clk, ap_rst_n (async low), bus (slave: addr/wr_data/rd_wr/ap_start -> idle/ready/done/return).
module duft_ap_ctrl_hs_mc #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int STAGES = 8,
  parameter int INC    = 1
) (
  input  logic                 clk,
  input  logic                 ap_rst_n,
  duft_ap_ctrl_hs_mc_if.slave  bus
);

  localparam logic [2:0] OP_INPUT = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_ENDR  = 3'd3;
  localparam logic [2:0] OP_TEST  = 3'd4;
  localparam logic [2:0] OP_NEXT  = 3'd5;
  localparam logic [2:0] OP_ENDT  = 3'd6;

  localparam logic [7:0]        ST    = 8'(STAGES);
  localparam logic [DATA_W-1:0] INC_W = DATA_W'(INC);

  typedef enum logic [1:0] {
    B_IDLE, B_ACC, B_DONE
  } bus_t;

  typedef enum logic [3:0] {
    C_IDLE      = 4'd0,
    C_IN_FLAT   = 4'd1,
    C_IN_DUT    = 4'd2,
    C_IN_RDY    = 4'd3,
    C_OUT_WAIT  = 4'd4,
    C_OUT_VAL   = 4'd5,
    C_OUT_PACK  = 4'd6,
    C_SCAN_PREP = 4'd7,
    C_SCAN      = 4'd8,
    C_SCAN_RD   = 4'd9,
    C_TICK      = 4'd10
  } core_t;

  bus_t        bus_st;
  logic [31:0] a_q;
  logic [31:0] d_q;
  logic        rd_q;
  logic [2:0]  op_q;
  logic        op_vld;
  logic [2:0]  op_code;
  logic [7:0]  cfg_step;
  logic [31:0] test_in;
  logic        err;
  logic [DATA_W-1:0] dut_in [LANES];

  core_t       core_st;
  logic [7:0]  cnt;
  logic [7:0]  rem;
  logic [31:0] cyc_cnt;
  logic [DATA_W-1:0] acc     [LANES];
  logic [DATA_W-1:0] dut_out [LANES];
  logic [DATA_W-1:0] dft_out [LANES];

  logic [2:0]  lane;
  logic        lane_ok;
  logic        last;
  logic        core_idle;
  logic [DATA_W-1:0] din_v;
  logic [DATA_W-1:0] dout_v;
  logic [DATA_W-1:0] dft_v;
  logic [31:0] rdata;
  logic        bus_err;
  logic        err_clr;
  logic        op_wr;
  logic        cfg_wr;
  logic        din_wr;
  logic        tin_wr;
  logic        op_ok;
  logic        go;
  logic [7:0]  step_eff;
  logic [7:0]  left;
  logic [7:0]  tick_n;

  assign lane      = a_q[2:0];
  assign lane_ok   = ({29'd0, lane} < 32'(LANES));
  assign last      = (cnt == ST);
  assign core_idle = (core_st == C_IDLE);
  assign step_eff  = (cfg_step == 8'd0) ? 8'd1 : cfg_step;
  assign left      = ST - cnt;
  assign tick_n    = (step_eff < left) ? step_eff : left;
  assign go        = op_vld && op_ok;

  always_comb begin
    din_v  = '0;
    dout_v = '0;
    dft_v  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane == 3'(l)) begin
        din_v  = dut_in[l];
        dout_v = dut_out[l];
        dft_v  = dft_out[l];
      end
    end
  end

  logic sel_op, sel_st, sel_cfg, sel_din;
  logic sel_dout, sel_dft, sel_cyc;
  logic sel_tin, sel_tout;

  assign sel_op   = (a_q == 32'h0000_0000);
  assign sel_st   = (a_q == 32'h0000_0001);
  assign sel_cfg  = (a_q == 32'h0000_0002);
  assign sel_din  = (a_q[31:3] == 29'h2) && lane_ok;
  assign sel_dout = (a_q[31:3] == 29'h3) && lane_ok;
  assign sel_dft  = (a_q[31:3] == 29'h4) && lane_ok;
  assign sel_cyc  = (a_q == 32'h0000_0028);
  assign sel_tin  = (a_q == 32'hFF00_0000);
  assign sel_tout = (a_q == 32'hFF00_0001);

  always_comb begin
    rdata   = '0;
    bus_err = 1'b0;
    err_clr = 1'b0;
    op_wr   = 1'b0;
    cfg_wr  = 1'b0;
    din_wr  = 1'b0;
    tin_wr  = 1'b0;
    if (bus_st == B_ACC) begin
      if (rd_q) begin
        unique case (1'b1)
          sel_op:   rdata = {29'd0, op_q};
          sel_st:   rdata = {18'd0, err, last, cnt, core_st};
          sel_cfg:  rdata = {24'd0, cfg_step};
          sel_din:  rdata = 32'(din_v);
          sel_dout: rdata = 32'(dout_v);
          sel_dft:  rdata = 32'(dft_v);
          sel_cyc:  rdata = cyc_cnt;
          sel_tin:  rdata = test_in;
          sel_tout: rdata = test_in;
          default:  bus_err = 1'b1;
        endcase
      end else begin
        unique case (1'b1)
          sel_op: begin
            if (d_q > 32'd6) bus_err = 1'b1;
            else             op_wr   = 1'b1;
          end
          sel_cfg: begin
            if (!core_idle) begin
              bus_err = 1'b1;
            end else begin
              cfg_wr  = 1'b1;
              err_clr = d_q[31];
            end
          end
          sel_din: begin
            if (!core_idle) bus_err = 1'b1;
            else            din_wr  = 1'b1;
          end
          sel_tin: tin_wr  = 1'b1;
          default: bus_err = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    op_ok = 1'b0;
    case (core_st)
      C_IDLE:    op_ok = (op_code == OP_INPUT);
      C_IN_RDY:  op_ok = (op_code == OP_RUN) ||
                         (op_code == OP_TEST);
      C_OUT_VAL: op_ok = (op_code == OP_ENDR);
      C_SCAN_RD: op_ok = (op_code == OP_NEXT) ||
                         (op_code == OP_ENDT);
      default:   op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      bus_st        <= B_IDLE;
      bus.ap_idle   <= 1'b1;
      bus.ap_done   <= 1'b0;
      bus.ap_ready  <= 1'b0;
      bus.ap_return <= '0;
      a_q           <= '0;
      d_q           <= '0;
      rd_q          <= 1'b0;
      op_q          <= '0;
      op_vld        <= 1'b0;
      op_code       <= '0;
      cfg_step      <= '0;
      test_in       <= '0;
      for (int l = 0; l < LANES; l++) dut_in[l] <= '0;
    end else begin
      op_vld <= 1'b0;
      case (bus_st)
        B_IDLE: begin
          if (bus.ap_start) begin
            a_q         <= bus.addr;
            d_q         <= bus.wr_data;
            rd_q        <= bus.rd_wr;
            bus.ap_idle <= 1'b0;
            bus_st      <= B_ACC;
          end
        end
        B_ACC: begin
          bus.ap_done  <= 1'b1;
          bus.ap_ready <= 1'b1;
          bus_st       <= B_DONE;
          if (rd_q) bus.ap_return <= rdata;
          if (op_wr) begin
            op_q    <= d_q[2:0];
            op_code <= d_q[2:0];
            op_vld  <= (d_q[2:0] != 3'd0);
          end
          if (cfg_wr) cfg_step <= d_q[7:0];
          if (tin_wr) test_in  <= d_q;
          for (int l = 0; l < LANES; l++) begin
            if (din_wr && lane == 3'(l))
              dut_in[l] <= d_q[DATA_W-1:0];
          end
        end
        B_DONE: begin
          bus.ap_done  <= 1'b0;
          bus.ap_ready <= 1'b0;
          bus.ap_idle  <= 1'b1;
          bus_st       <= B_IDLE;
        end
        default: bus_st <= B_IDLE;
      endcase
    end
  end

  // Bus faults and illegal core ops share one sticky flag.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err <= 1'b0;
    end else begin
      if (err_clr) err <= 1'b0;
      if (bus_err || (op_vld && !op_ok)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      core_st <= C_IDLE;
      cnt     <= '0;
      rem     <= '0;
      cyc_cnt <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc[l]     <= '0;
        dut_out[l] <= '0;
        dft_out[l] <= '0;
      end
    end else begin
      case (core_st)
        C_IDLE: begin
          if (go) core_st <= C_IN_FLAT;
        end
        C_IN_FLAT: core_st <= C_IN_DUT;
        C_IN_DUT: begin
          for (int l = 0; l < LANES; l++) acc[l] <= dut_in[l];
          cnt     <= '0;
          core_st <= C_IN_RDY;
        end
        C_IN_RDY: begin
          if (go && op_code == OP_RUN)  core_st <= C_OUT_WAIT;
          if (go && op_code == OP_TEST) core_st <= C_SCAN_PREP;
        end
        C_OUT_WAIT: begin
          for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + INC_W;
          cnt     <= cnt + 8'd1;
          cyc_cnt <= cyc_cnt + 32'd1;
          if (cnt == ST - 8'd1) core_st <= C_OUT_VAL;
        end
        C_OUT_VAL: begin
          if (go) core_st <= C_OUT_PACK;
        end
        C_OUT_PACK: begin
          for (int l = 0; l < LANES; l++) dut_out[l] <= acc[l];
          core_st <= C_IDLE;
        end
        C_SCAN_PREP: core_st <= C_SCAN;
        C_SCAN: begin
          for (int l = 0; l < LANES; l++) dft_out[l] <= acc[l];
          core_st <= C_SCAN_RD;
        end
        C_SCAN_RD: begin
          // NEXT at the last stage is legal but does nothing.
          if (go && op_code == OP_NEXT && cnt < ST) begin
            rem     <= tick_n;
            core_st <= C_TICK;
          end
          if (go && op_code == OP_ENDT) core_st <= C_IDLE;
        end
        C_TICK: begin
          for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + INC_W;
          cnt     <= cnt + 8'd1;
          cyc_cnt <= cyc_cnt + 32'd1;
          rem     <= rem - 8'd1;
          if (rem == 8'd1) core_st <= C_SCAN;
        end
        default: core_st <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duft_ap_ctrl_hs_mc.sv
// tb_duft_ap_ctrl_hs_mc: directed scoreboard bench for duft_ap_ctrl_hs_mc.
// Stimulus pushes expected ap_return per access; a negedge monitor checks.
module tb_duft_ap_ctrl_hs_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  duft_ap_ctrl_hs_mc_if bus ();

  duft_ap_ctrl_hs_mc #(
    .DATA_W(32), .LANES(2), .STAGES(8), .INC(1)
  ) dut (
    .clk(clk),
    .ap_rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          busy = 0;
  bit          rst_seen = 1'b0;
  logic [31:0] last_exp = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      if (!rst_seen) begin
        n_total++;
        if (bus.ap_idle === 1'b1 && bus.ap_done === 1'b0 &&
            bus.ap_ready === 1'b0 && bus.ap_return === 32'h0)
          n_pass++;
        else
          $display("FAIL reset_state: idle=%b done=%b ready=%b ret=%h, want 1 0 0 0",
                   bus.ap_idle, bus.ap_done, bus.ap_ready, bus.ap_return);
      end
      rst_seen = 1'b1;
      sb.delete();
      busy = 0;
    end else begin
      rst_seen = 1'b0;
      busy = bus.ap_idle ? 0 : busy + 1;
      if (bus.ap_done) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_done: busy=%0d, want no done", busy);
        end else begin
          e = sb.pop_front();
          if (bus.ap_return === e.exp && bus.ap_ready === 1'b1 && busy == 2)
            n_pass++;
          else
            $display("FAIL %s: ret=%h ready=%b lat=%0d, want ret=%h ready=1 lat=2",
                     e.nm, bus.ap_return, bus.ap_ready, busy, e.exp);
        end
      end else if (busy == 4) begin
        n_total++;
        $display("FAIL bus_timeout: busy=%0d cycles, want 2", busy);
      end
    end
  end

  task automatic access(input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] e,
                        input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.ap_idle && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.ap_idle) begin
      $display("FAIL %s: bus not idle, got idle=%b want 1", nm, bus.ap_idle);
      $fatal(1, "bus stuck");
    end
    bus.addr     = a;
    bus.wr_data  = d;
    bus.rd_wr    = r;
    bus.ap_start = 1'b1;
    if (r) last_exp = e;
    sb.push_back('{nm, last_exp});
    @(posedge clk);
    #1 bus.ap_start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.ap_idle && k < 20);
    if (!bus.ap_idle) begin
      $display("FAIL %s: access never finished, got idle=%b want 1", nm, bus.ap_idle);
      $fatal(1, "bus stuck");
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    access(1'b0, a, d, 32'h0, "wr_hold");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string nm);
    access(1'b1, a, 32'h0, e, nm);
  endtask

  task automatic op(input logic [31:0] code);
    wr(32'h0, code);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.addr     = '0;
    bus.wr_data  = '0;
    bus.rd_wr    = 1'b0;
    bus.ap_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd(32'h1, 32'h0, "state_rst");
    rd(32'h2, 32'h0, "cfg_rst");
    rd(32'h28, 32'h0, "cyc_rst");

    wr(32'hFF00_0000, 32'h7216);
    rd(32'hFF00_0001, 32'h7216, "test_out");
    rd(32'hFF00_0000, 32'h7216, "test_in");

    wr(32'h10, 32'h7216);
    wr(32'h11, 32'h0722);
    rd(32'h11, 32'h0722, "dut_in1");
    op(32'd1);
    op(32'd2);
    rd(32'h1, 32'h0074, "state_wait");
    repeat (4) @(negedge clk);
    rd(32'h1, 32'h1085, "state_outval");
    op(32'd3);
    rd(32'h18, 32'h721E, "dut_out0");
    rd(32'h19, 32'h072A, "dut_out1");
    rd(32'h28, 32'd8, "cyc_run1");

    wr(32'h10, 32'hFFFF_FFFC);
    op(32'd1);
    op(32'd2);
    repeat (12) @(negedge clk);
    op(32'd3);
    rd(32'h18, 32'h4, "dut_out0_wrap");
    rd(32'h28, 32'd16, "cyc_run2");

    wr(32'h10, 32'h7216);
    op(32'd1);
    op(32'd4);
    rd(32'h20, 32'h7216, "dft0_s1_init");
    rd(32'h1, 32'h0009, "state_scan_rd");
    for (int i = 1; i <= 8; i++) begin
      op(32'd5);
      rd(32'h20, 32'h7216 + 32'(i), "dft0_s1_step");
    end
    rd(32'h21, 32'h072A, "dft1_s1_end");
    rd(32'h1, 32'h1089, "state_last");
    op(32'd5);
    rd(32'h20, 32'h721E, "dft0_s1_sat");
    rd(32'h1, 32'h1089, "state_sat_noerr");
    op(32'd6);
    rd(32'h1, 32'h1080, "state_endt");
    rd(32'h18, 32'h4, "dut_out0_kept");
    rd(32'h28, 32'd24, "cyc_dft1");

    wr(32'h2, 32'h3);
    rd(32'h2, 32'h3, "cfg_step3");
    op(32'd1);
    op(32'd4);
    rd(32'h20, 32'h7216, "dft0_s3_init");
    op(32'd5);
    rd(32'h20, 32'h7219, "dft0_s3_a");
    op(32'd5);
    rd(32'h20, 32'h721C, "dft0_s3_b");
    op(32'd5);
    rd(32'h20, 32'h721E, "dft0_s3_sat");
    rd(32'h1, 32'h1089, "state_s3_last");
    rd(32'h28, 32'd32, "cyc_dft3");
    op(32'd6);

    op(32'd2);
    rd(32'h1, 32'h3080, "err_run_idle");
    rd(32'h5, 32'h0, "rd_unmapped");
    wr(32'h2, 32'h8000_0000);
    rd(32'h1, 32'h1080, "err_cleared");
    rd(32'h2, 32'h0, "cfg_clr_reads0");
    wr(32'h0, 32'h7);
    rd(32'h0, 32'h2, "opcode_bad_kept");
    rd(32'h1, 32'h3080, "err_opcode7");
    wr(32'h2, 32'h8000_0000);
    rd(32'h12, 32'h0, "rd_lane2");
    rd(32'h1, 32'h3080, "err_lane2");

    wr(32'h10, 32'h100);
    op(32'd1);
    wr(32'h0, 32'd2);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.addr     = 32'h1;
    bus.rd_wr    = 1'b1;
    bus.ap_start = 1'b1;
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.ap_start = 1'b0;
    last_exp     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(32'h1, 32'h0, "state_after_rst");
    rd(32'h18, 32'h0, "dut_out0_after_rst");
    rd(32'h28, 32'h0, "cyc_after_rst");
    rd(32'h10, 32'h0, "dut_in0_after_rst");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/duft_ap_ctrl_hs_mc.md
# duft_ap_ctrl_hs_mc

Parametrised multi-lane design-under-functional-test (DUFT) wrapper with an HLS ap_ctrl_hs register-access port. Holds LANES independent accumulator DUT lanes behind an address-mapped register file. Runs them functionally (RUN) or as a scan-observable, stepped test (TEST/NEXT) with a configurable step size. Successor to the single-lane DUFT wrapper; the opcode set and core state encodings are unchanged.

## Interface
- DATA_W, 32: lane datapath width (≤32); wr_data[DATA_W-1:0] used, ap_return zero-extended.
- LANES, 2: number of DUT lanes (1..8).
- STAGES, 8: DUT ticks per run (1..255).
- INC, 1: per-tick increment of every lane.
- clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- addr  in  32  register address, sampled when ap_start accepted.
- wr_data  in  32  write data.
- rd_wr  in  1  1 = read, 0 = write.
- ap_start  in  1  access request.
- ap_idle  out  1  bus FSM idle, ready to accept.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- ap_done  out  1  one-cycle pulse, access complete.
- ap_return  out  32  read data; held until the next read completes.

## Operation
- Address map:
  - 0x00 OPCODE (R/W).
  - 0x01 STATE (R): [3:0] core state, [11:4] tick count, [12] last (cnt==STAGES), [13] sticky err.
  - 0x02 CONFIG (R/W): [7:0] step size (0 treated as 1), [31] err clear (self-clearing, reads 0).
  - 0x10+l DUT_IN (R/W).
  - 0x18+l DUT_OUT (R).
  - 0x20+l DFT_OUT (R), snapshot.
  - 0x28 CYCLE_CNT (R), total ticks since reset, 32-bit wrap.
  - 0xFF000000 TEST_IN (R/W).
  - 0xFF000001 TEST_OUT (R) = TEST_IN.
- Lane registers: l < LANES only. Any other address: read returns 0, err set; write ignored, err set.
- OPCODE write of a nonzero value issues a one-cycle op pulse to the core. Writing NONE only updates readback. Opcode > 6 ignored, err set.
- Opcodes: NONE 0, INPUT 1, RUN 2, ENDR 3, TEST 4, NEXT 5, ENDT 6.
- Core states: IDLE 0, INPUT_FLATTEN 1, INPUT_DUT 2, INPUT_RDY 3, OUTPUT_WAIT 4, OUTPUT_VAL 5, OUTPUT_PACK 6, SCAN_PREP 7, SCAN 8, SCAN_RD 9, TICK 10.
- Transitions:
  - IDLE + INPUT → INPUT_FLATTEN → INPUT_DUT (acc[l]=DUT_IN[l], cnt=0) → INPUT_RDY.
  - INPUT_RDY + RUN → OUTPUT_WAIT: acc[l]+=INC and cnt++ each cycle; at cnt==STAGES → OUTPUT_VAL.
  - OUTPUT_VAL + ENDR → OUTPUT_PACK (DUT_OUT[l]=acc[l]) → IDLE.
  - INPUT_RDY + TEST → SCAN_PREP → SCAN (DFT_OUT[l]=acc[l]) → SCAN_RD.
  - SCAN_RD + NEXT with cnt<STAGES → TICK for min(step, STAGES−cnt) cycles, one tick per cycle → SCAN → SCAN_RD.
  - SCAN_RD + NEXT with cnt==STAGES: no change, no error.
  - SCAN_RD + ENDT → IDLE; DUT_OUT untouched.
- Any op not legal in the current state: ignored, err set. Ops arriving in non-waiting states are also ignored with err.
- DUT_IN and CONFIG writes while core ≠ IDLE: ignored, err set.
- Arithmetic: acc modulo 2^DATA_W; result = in + STAGES·INC mod 2^DATA_W.

## Timing
- Reset (async assert, sync-safe deassert): ap_idle=1, ap_done=0, ap_ready=0, ap_return=0, core IDLE. All registers, counters and err cleared; CONFIG=0.
- Bus FSM: B_IDLE (ap_idle=1) → B_ACC (1 cycle, register read/write) → B_DONE (ap_done=ap_ready=1, ap_idle=0) → B_IDLE.
- ap_start is sampled only in B_IDLE. Done is asserted 2 cycles after the accepting edge.
- A held ap_start re-triggers only after ap_idle returns high.
- Op pulse reaches the core on the cycle after B_ACC. A STATE read reflects the state at its own B_ACC cycle.
- RUN latency: OUTPUT_VAL reached STAGES+1 cycles after the op pulse.
- Reset mid-operation aborts immediately; no partial DUT_OUT or DFT_OUT update survives.

## Test plan
- Loopback: write TEST_IN 0x7216, read TEST_OUT → 0x7216. Each access: ap_done high exactly 1 cycle, 2 cycles after start accepted; ap_idle low during the access.
- DUT run (LANES=2): DUT_IN 0x7216/0x0722, INPUT, RUN, ENDR → DUT_OUT 0x721E/0x072A. Lane 0 in 0xFFFFFFFC → 0x00000004.
- DFT step=1: in 0x7216, INPUT, TEST → DFT_OUT0 0x7216, cnt 0. 8×NEXT → 0x7217..0x721E, STATE[12]=1. 9th NEXT → unchanged, err 0. ENDT → STATE[3:0]=0.
- DFT step=3 (CONFIG=3): snapshots 0x7216, 0x7219, 0x721C, 0x721E (saturated). CYCLE_CNT advances by 8.
- Errors: RUN from IDLE → state 0, STATE[13]=1. Read 0x00000005 → 0. Opcode 7 ignored. CONFIG write 0x80000000 → STATE[13]=0.
- Reset: drop ap_rst_n during OUTPUT_WAIT → same-cycle ap_idle=1, state IDLE, DUT_OUT0=0, CYCLE_CNT=0.
